// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants, FSM state encoding and the
// baud divisor helper used by both the receive and the future transmit path.
package uart_pkg;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_START  = 4'd7;
  localparam logic [3:0] MID_BIT    = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } uart_state_t;

  // Clocks per oversample tick, truncated and never below one.
  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..DIV-1 counter with a synchronous
// clear so the phase can be realigned to a start edge.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling, framing-error/overrun pulses and a
// single-entry output buffer drained through a valid/ready handshake.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int DIV      = calc_div(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic        r_sync1, r_sync2;
  logic        w_rxd_s;
  uart_state_t r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shreg, w_shreg_nxt;
  logic        w_tick, w_clr, w_commit, w_ferr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxd_s = r_sync2;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Partial bytes are never observed outside a committed frame, so no reset.
  always_ff @(posedge clk) begin
    r_shreg <= w_shreg_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_clr       = 1'b0;
    w_commit    = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxd_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_cnt == MID_START) begin
            if (w_rxd_s) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DATA;
              w_cnt_nxt   = '0;
              w_bit_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == MID_BIT) begin
            w_shreg_nxt = {w_rxd_s, r_shreg[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              w_state_nxt = S_STOP;
            end
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == MID_BIT) begin
            if (w_rxd_s) begin
              w_commit    = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_ferr      = 1'b1;
              w_state_nxt = S_BRK;
            end
          end
        end
      end
      S_BRK: begin
        // A held-low line must not retrigger framing errors until it idles.
        if (w_rxd_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_ferr;
      overrun   <= w_commit && rx_valid && !rx_ready;
      if (w_commit && (!rx_valid || rx_ready)) begin
        rx_data  <= r_shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at DIV=2 (32 clocks per bit).
module tb_uart_rx_byte;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_ferr = 0;
  int n_ovr  = 0;

  uart_rx_byte #(.CLK_FREQ(50000000), .BAUD(1152000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  // Counts clocks during which each pulse output is high.
  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overrun)   n_ovr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      $error("%s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drives clock slots i0..i1-1 of an 8N1 frame; slot i carries bit i/32.
  // rx_ready is high only during the clock that ends at edge ready_at+1.
  task automatic drive_frame(input logic [7:0] data, input logic stop_bit,
                             input int ready_at, input int i0, input int i1);
    logic [9:0] fr;
    fr = {stop_bit, data, 1'b0};
    for (int i = i0; i < i1; i++) begin
      @(posedge clk);
      #1;
      rxd      = fr[i/32];
      rx_ready = (i == ready_at);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_rx_data",   32'(rx_data),   32'h0);
    check("reset_rx_valid",  32'(rx_valid),  32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun",   32'(overrun),   32'h0);
    check("reset_busy",      32'(busy),      32'h0);
    idle(5);

    drive_frame(8'hA5, 1'b1, -1, 0, 100);
    check("a5_busy_mid", 32'(busy), 32'h1);
    drive_frame(8'hA5, 1'b1, -1, 100, 320);
    check("a5_valid", 32'(rx_valid), 32'h1);
    check("a5_data",  32'(rx_data),  32'hA5);
    check("a5_ferr",  32'(n_ferr),   32'h0);
    check("a5_idle",  32'(busy),     32'h0);
    idle(4);
    check("a5_hold", 32'(rx_data), 32'hA5);
    pulse_ready();
    check("a5_consumed", 32'(rx_valid), 32'h0);

    drive_frame(8'h3C, 1'b1, -1, 0, 320);
    drive_frame(8'hC3, 1'b1, -1, 0, 320);
    check("ovr_data",  32'(rx_data),  32'h3C);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    check("ovr_count", 32'(n_ovr),    32'h1);
    pulse_ready();
    check("ovr_consumed", 32'(rx_valid), 32'h0);

    drive_frame(8'h3C, 1'b1, -1, 0, 320);
    drive_frame(8'hC3, 1'b1, 306, 0, 320);
    check("swap_data",  32'(rx_data),  32'hC3);
    check("swap_valid", 32'(rx_valid), 32'h1);
    check("swap_no_ovr", 32'(n_ovr),   32'h1);
    pulse_ready();
    check("swap_consumed", 32'(rx_valid), 32'h0);

    @(posedge clk);
    #1 rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    check("glitch_busy", 32'(busy), 32'h1);
    idle(40);
    check("glitch_idle",  32'(busy),     32'h0);
    check("glitch_valid", 32'(rx_valid), 32'h0);
    check("glitch_ferr",  32'(n_ferr),   32'h0);
    check("glitch_ovr",   32'(n_ovr),    32'h1);

    drive_frame(8'h55, 1'b0, -1, 0, 320);
    check("ferr_count", 32'(n_ferr),   32'h1);
    check("ferr_valid", 32'(rx_valid), 32'h0);
    idle(40 * 32);
    check("brk_one_ferr", 32'(n_ferr), 32'h1);
    check("brk_busy",     32'(busy),   32'h1);
    rxd = 1'b1;
    idle(64);
    check("brk_released", 32'(busy), 32'h0);
    drive_frame(8'h81, 1'b1, -1, 0, 320);
    check("after_brk_data",  32'(rx_data),  32'h81);
    check("after_brk_valid", 32'(rx_valid), 32'h1);

    drive_frame(8'hFF, 1'b1, -1, 0, 170);
    rst = 1'b0;
    #1;
    check("mid_rst_data",  32'(rx_data),   32'h0);
    check("mid_rst_valid", 32'(rx_valid),  32'h0);
    check("mid_rst_busy",  32'(busy),      32'h0);
    check("mid_rst_ferr",  32'(frame_err), 32'h0);
    check("mid_rst_ovr",   32'(overrun),   32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    rxd = 1'b1;
    idle(400);
    check("post_rst_busy",  32'(busy),     32'h0);
    check("post_rst_valid", 32'(rx_valid), 32'h0);

    drive_frame(8'h0F, 1'b1, -1, 0, 320);
    check("final_data",  32'(rx_data),  32'h0F);
    check("final_valid", 32'(rx_valid), 32'h1);
    check("final_ferr",  32'(n_ferr),   32'h1);
    check("final_ovr",   32'(n_ovr),    32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
